// File: rtl/ppu_bus_arb.sv
// PPU memory-port arbiter: render fetches have strict priority, CPU PPUDATA ops
// wait behind them but pre-empt one render slot after STARVE_MAX cycles.
module ppu_bus_arb #(
    parameter int unsigned ADDR_W     = 14,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rend_req,
    input  logic [ADDR_W-1:0] rend_addr,
    output logic [7:0]        rend_data,
    output logic              rend_valid,
    output logic              rend_drop,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic [7:0]        cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rw,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {C_IDLE, C_WAIT, C_RD} cpu_state_t;
    typedef enum logic [1:0] {T_NONE, T_REND, T_CPU} tag_t;

    cpu_state_t        state;
    tag_t              tag;
    logic              lat_rw;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [CNT_W-1:0]  wait_cnt;
    logic [DATA_W-1:0] rend_data_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic              cpu_grant;
    logic              rend_grant;

    // Slot decision for this cycle
    always_comb begin
        cpu_grant  = (state == C_WAIT) &&
                     (!rend_req || (wait_cnt >= CNT_W'(STARVE_MAX)));
        rend_grant = rend_req && !cpu_grant;
    end

    // Memory port driven straight from the decision; address forced to 0 in reset
    always_comb begin
        mem_addr  = rend_addr;
        mem_rw    = 1'b1;
        mem_wdata = '0;
        if (rst) begin
            mem_addr = '0;
        end else if (cpu_grant) begin
            mem_addr  = lat_addr;
            mem_rw    = lat_rw;
            mem_wdata = lat_wdata;
        end
    end

    // Read data is forwarded in the cycle it arrives and held afterwards
    always_comb begin
        rend_valid = (tag == T_REND);
        rend_drop  = cpu_grant && rend_req;
        rend_data  = rend_valid ? mem_rdata : rend_data_q;
        cpu_busy   = (state != C_IDLE);
        cpu_done   = (cpu_grant && !lat_rw) || (state == C_RD);
        cpu_rdata  = (state == C_RD) ? mem_rdata : cpu_rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= C_IDLE;
            tag         <= T_NONE;
            lat_rw      <= 1'b1;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            wait_cnt    <= '0;
            rend_data_q <= '0;
            cpu_rdata_q <= '0;
        end else begin
            if (cpu_grant)       tag <= T_CPU;
            else if (rend_grant) tag <= T_REND;
            else                 tag <= T_NONE;

            if (rend_valid) rend_data_q <= mem_rdata;

            case (state)
                C_IDLE: begin
                    if (cpu_req) begin
                        lat_rw    <= cpu_rw;
                        lat_addr  <= cpu_addr;
                        lat_wdata <= cpu_wdata;
                        wait_cnt  <= '0;
                        state     <= C_WAIT;
                    end
                end
                C_WAIT: begin
                    if (cpu_grant) begin
                        wait_cnt <= '0;
                        state    <= lat_rw ? C_RD : C_IDLE;
                    end else if (wait_cnt != {CNT_W{1'b1}}) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                C_RD: begin
                    cpu_rdata_q <= mem_rdata;
                    state       <= C_IDLE;
                end
                default: state <= C_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ppu_bus_arb.sv
// Scoreboard bench for ppu_bus_arb: directed stimulus pushes expected completions,
// a negedge monitor pops and compares whenever the DUT presents a result.
module tb_ppu_bus_arb;
    localparam int unsigned ADDR_W     = 14;
    localparam int unsigned STARVE_MAX = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              rend_req = 1'b0;
    logic [ADDR_W-1:0] rend_addr = '0;
    logic [7:0]        rend_data;
    logic              rend_valid;
    logic              rend_drop;
    logic              cpu_req = 1'b0;
    logic              cpu_rw = 1'b1;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [7:0]        cpu_wdata = '0;
    logic              cpu_busy;
    logic              cpu_done;
    logic [7:0]        cpu_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rw;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    ppu_bus_arb #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .rend_req(rend_req), .rend_addr(rend_addr), .rend_data(rend_data),
        .rend_valid(rend_valid), .rend_drop(rend_drop),
        .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory map model: 1-cycle registered read, CHR 0..15 preloaded in reset
    logic [7:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'(i * 7 + 3);
            mem_rdata <= '0;
        end else begin
            if (!mem_rw) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    function automatic logic [7:0] chr(int a);
        return 8'(a * 7 + 3);
    endfunction

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } rend_exp_t;

    typedef struct {
        int          cyc;
        logic        rd;
        logic [13:0] addr;
        logic [7:0]  data;
    } cpu_exp_t;

    rend_exp_t rq[$];
    cpu_exp_t  cq[$];
    int        dq[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(string name);
        checks++;
        failures++;
        $display("FAIL %s actual=asserted required=no_event cycle=%0d", name, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(string pfx);
        chk({pfx, "_busy"}, 32'(cpu_busy), 0);
        chk({pfx, "_done"}, 32'(cpu_done), 0);
        chk({pfx, "_cpu_rdata"}, 32'(cpu_rdata), 0);
        chk({pfx, "_rend_data"}, 32'(rend_data), 0);
        chk({pfx, "_rend_valid"}, 32'(rend_valid), 0);
        chk({pfx, "_rend_drop"}, 32'(rend_drop), 0);
        chk({pfx, "_mem_addr"}, 32'(mem_addr), 0);
        chk({pfx, "_mem_rw"}, 32'(mem_rw), 1);
        chk({pfx, "_mem_wdata"}, 32'(mem_wdata), 0);
    endtask

    // Monitor: compare whatever the DUT presents against the queued expectations
    rend_exp_t re;
    cpu_exp_t  ce;
    always @(negedge clk) begin
        if (!rst) begin
            if (rend_valid) begin
                if (rq.size() == 0) unexpected("rend_valid");
                else begin
                    re = rq.pop_front();
                    chk("rend_cycle", 32'(cyc), 32'(re.cyc));
                    chk("rend_data", 32'(rend_data), 32'(re.data));
                end
            end
            if (rend_drop) begin
                if (dq.size() == 0) unexpected("rend_drop");
                else chk("drop_cycle", 32'(cyc), 32'(dq.pop_front()));
            end
            if (cpu_done) begin
                if (cq.size() == 0) unexpected("cpu_done");
                else begin
                    ce = cq.pop_front();
                    chk("cpu_done_cycle", 32'(cyc), 32'(ce.cyc));
                    if (ce.rd) begin
                        chk("cpu_rdata", 32'(cpu_rdata), 32'(ce.data));
                    end else begin
                        chk("wr_mem_rw", 32'(mem_rw), 0);
                        chk("wr_mem_addr", 32'(mem_addr), 32'(ce.addr));
                        chk("wr_mem_wdata", 32'(mem_wdata), 32'(ce.data));
                    end
                end
            end
        end
    end

    initial begin
        int n;
        rend_addr = 14'h0155;
        #2 rst = 1'b1;
        tick();
        tick();
        check_reset("init");
        rst = 1'b0;
        rend_addr = '0;
        tick();

        // Write on idle bus, then read it back
        n = cyc;
        cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 14'h2005; cpu_wdata = 8'hA7;
        cq.push_back('{n + 1, 1'b0, 14'h2005, 8'hA7});
        tick();
        cpu_req = 1'b0;
        chk("wr_busy_n1", 32'(cpu_busy), 1);
        tick();
        chk("wr_busy_n2", 32'(cpu_busy), 0);
        tick();
        cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 14'h2005;
        cq.push_back('{n + 5, 1'b1, 14'h2005, 8'hA7});
        tick();
        cpu_req = 1'b0;
        chk("rd_mem_rw", 32'(mem_rw), 1);
        chk("rd_mem_addr", 32'(mem_addr), 32'h2005);
        tick();
        tick();
        chk("rd_hold_rdata", 32'(cpu_rdata), 32'hA7);
        chk("rd_busy_after", 32'(cpu_busy), 0);

        // Back-to-back render reads of CHR 0..15
        for (int i = 0; i < 16; i++) begin
            n = cyc;
            rend_req = 1'b1; rend_addr = 14'(i);
            rq.push_back('{n + 1, chr(i)});
            tick();
        end
        rend_req = 1'b0;
        tick();
        tick();

        // Continuous render with a CPU read: starvation guard pre-empts slot N+9
        n = cyc;
        for (int k = 0; k < 15; k++) begin
            rend_req = 1'b1; rend_addr = 14'(k % 16);
            cpu_req = (k == 0); cpu_rw = 1'b1; cpu_addr = 14'h0003;
            if (k != 9) rq.push_back('{n + k + 1, chr(k % 16)});
            if (k == 9) dq.push_back(n + 9);
            if (k == 0) cq.push_back('{n + 10, 1'b1, 14'h0003, chr(3)});
            tick();
        end
        rend_req = 1'b0; cpu_req = 1'b0;
        tick();
        tick();

        // Render stops at N+3 while CPU write waits: CPU takes the free slot
        n = cyc;
        for (int k = 0; k < 4; k++) begin
            rend_req = (k < 3); rend_addr = 14'(k);
            cpu_req = (k == 0); cpu_rw = 1'b0; cpu_addr = 14'h0100; cpu_wdata = 8'h5A;
            if (k < 3) rq.push_back('{n + k + 1, chr(k)});
            if (k == 0) cq.push_back('{n + 3, 1'b0, 14'h0100, 8'h5A});
            tick();
        end
        rend_req = 1'b0; cpu_req = 1'b0;
        tick();

        // Strobe while busy is dropped
        n = cyc;
        cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 14'h0200; cpu_wdata = 8'h11;
        cq.push_back('{n + 1, 1'b0, 14'h0200, 8'h11});
        tick();
        cpu_addr = 14'h0300; cpu_wdata = 8'h22;
        chk("ign_busy", 32'(cpu_busy), 1);
        tick();
        cpu_req = 1'b0;
        chk("ign_mem_rw", 32'(mem_rw), 1);
        chk("ign_busy_clear", 32'(cpu_busy), 0);
        tick();
        n = cyc;
        cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 14'h0200;
        cq.push_back('{n + 2, 1'b1, 14'h0200, 8'h11});
        tick();
        cpu_req = 1'b0;
        tick();
        tick();
        tick();

        // Async reset while a CPU read waits behind render
        n = cyc;
        rend_req = 1'b1; rend_addr = 14'h0000;
        cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 14'h0005;
        rq.push_back('{n + 1, chr(0)});
        tick();
        cpu_req = 1'b0; rend_addr = 14'h0001;
        tick();
        rend_addr = 14'h0002;
        chk("pre_rst_busy", 32'(cpu_busy), 1);
        rst = 1'b1;
        #1;
        check_reset("mid");
        rend_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 12; k++) tick();

        chk("rend_queue_empty", 32'(rq.size()), 0);
        chk("cpu_queue_empty", 32'(cq.size()), 0);
        chk("drop_queue_empty", 32'(dq.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
